// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - 2-bit saturating counter branch predictor with registered mispredict pulse
// Optional gshare indexing is compiled in with `define BP_GSHARE_EN.
module branch_predictor #(
    parameter int INDEX_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_valid,
    input  logic [31:0]           fetch_pc,
    output logic                  pred_taken,
    output logic [INDEX_BITS-1:0] pred_index,
    input  logic                  resolve_valid,
    input  logic [INDEX_BITS-1:0] resolve_index,
    input  logic                  resolve_taken,
    input  logic                  resolve_pred,
    output logic                  mispredict,
    output logic                  redirect_taken
);
    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [1:0]            ctr [ENTRIES];
    logic [INDEX_BITS-1:0] base_index;
    logic [INDEX_BITS-1:0] lookup_index;
    logic                  unused_pc;

    assign base_index = fetch_pc[INDEX_BITS+1:2];
    assign unused_pc  = ^{fetch_pc[31:INDEX_BITS+2], fetch_pc[1:0]};

`ifdef BP_GSHARE_EN
    logic [INDEX_BITS-1:0] ghr;

    // History moves only on resolved outcomes, so it never needs repair.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr <= '0;
        end else if (resolve_valid) begin
            ghr <= {ghr[INDEX_BITS-2:0], resolve_taken};
        end
    end

    assign lookup_index = base_index ^ ghr;
`else
    assign lookup_index = base_index;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= 2'b01;
            end
        end else if (resolve_valid) begin
            if (resolve_taken && ctr[resolve_index] != 2'b11) begin
                ctr[resolve_index] <= ctr[resolve_index] + 2'b01;
            end else if (!resolve_taken && ctr[resolve_index] != 2'b00) begin
                ctr[resolve_index] <= ctr[resolve_index] - 2'b01;
            end
        end
    end

    // Lookup reads the pre-update counter; a same-cycle write lands after this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_taken <= 1'b0;
            pred_index <= '0;
        end else if (fetch_valid) begin
            pred_taken <= ctr[lookup_index][1];
            pred_index <= lookup_index;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mispredict     <= 1'b0;
            redirect_taken <= 1'b0;
        end else begin
            mispredict <= resolve_valid & (resolve_taken ^ resolve_pred);
            if (resolve_valid) begin
                redirect_taken <= resolve_taken;
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - self-checking bench for branch_predictor (vectors, sequences, random vs model)
module tb_branch_predictor;
    localparam int IB = 4;
    localparam int N  = 1 << IB;
`ifdef BP_GSHARE_EN
    localparam int GS = 1;
`else
    localparam int GS = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_valid;
    logic [31:0]   fetch_pc;
    logic          pred_taken;
    logic [IB-1:0] pred_index;
    logic          resolve_valid;
    logic [IB-1:0] resolve_index;
    logic          resolve_taken;
    logic          resolve_pred;
    logic          mispredict;
    logic          redirect_taken;

    always #5 clk = ~clk;

    branch_predictor #(.INDEX_BITS(IB)) dut (
        .clk(clk), .rst(rst),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .pred_taken(pred_taken), .pred_index(pred_index),
        .resolve_valid(resolve_valid), .resolve_index(resolve_index),
        .resolve_taken(resolve_taken), .resolve_pred(resolve_pred),
        .mispredict(mispredict), .redirect_taken(redirect_taken)
    );

    int total = 0;
    int bad   = 0;

    // Reference state kept as plain integers
    int m_ctr [N];
    int m_ghr;
    int m_taken, m_idx, m_misp, m_redir;

    typedef struct {
        bit          fv;
        logic [31:0] pc;
        bit          rv;
        int          ri;
        bit          rt;
        bit          rp;
        int          et;
        int          ei;
        int          em;
        int          er;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_ctr[i] = 1;
        m_ghr = 0; m_taken = 0; m_idx = 0; m_misp = 0; m_redir = 0;
    endtask

    // Drive one cycle, advance the model, then compare DUT against the model.
    task automatic step(input bit r, input bit fv, input logic [31:0] pc,
                        input bit rv, input int ri, input bit rt, input bit rp);
        rst = r; fetch_valid = fv; fetch_pc = pc;
        resolve_valid = rv; resolve_index = IB'(ri);
        resolve_taken = rt; resolve_pred = rp;
        if (r) begin
            model_reset();
        end else begin
            if (fv) begin
                m_idx   = ((int'(pc) >>> 2) & (N - 1)) ^ (GS != 0 ? m_ghr : 0);
                m_taken = (m_ctr[m_idx] >= 2) ? 1 : 0;
            end
            m_misp = (rv && (rt != rp)) ? 1 : 0;
            if (rv) begin
                m_redir = rt;
                m_ctr[ri] = rt ? ((m_ctr[ri] + 1 > 3) ? 3 : m_ctr[ri] + 1)
                               : ((m_ctr[ri] - 1 < 0) ? 0 : m_ctr[ri] - 1);
                m_ghr = (m_ghr * 2 + rt) % N;
            end
        end
        @(posedge clk);
        #1;
        chk("model_pred_taken", int'(pred_taken), m_taken);
        chk("model_pred_index", int'(pred_index), m_idx);
        chk("model_mispredict", int'(mispredict), m_misp);
        chk("model_redirect",   int'(redirect_taken), m_redir);
    endtask

    task automatic add(input bit fv, input logic [31:0] pc, input bit rv, input int ri,
                       input bit rt, input bit rp, input int et, input int ei,
                       input int em, input int er);
        vec_t v;
        v.fv = fv; v.pc = pc; v.rv = rv; v.ri = ri; v.rt = rt; v.rp = rp;
        v.et = et; v.ei = ei; v.em = em; v.er = er;
        tbl.push_back(v);
    endtask

    initial begin
        model_reset();
        rst = 1'b1; fetch_valid = 1'b0; fetch_pc = '0;
        resolve_valid = 1'b0; resolve_index = '0; resolve_taken = 1'b0; resolve_pred = 1'b0;

        // Two reset cycles with noisy inputs that must be ignored
        step(1, 1, 32'h0000_0014, 1, 5, 1, 0);
        chk("reset_mispredict", int'(mispredict), 0);
        step(1, 1, 32'h0000_001c, 1, 7, 0, 1);
        chk("reset_pred_index", int'(pred_index), 0);

`ifndef BP_GSHARE_EN
        // fv  pc         rv ri rt rp   taken idx misp redir
        add(1, 32'h40,    0, 0, 0, 0,   0, 0, 0, 0);
        add(0, 32'h0,     1, 5, 1, 1,   0, 0, 0, 1);
        add(0, 32'h0,     1, 5, 1, 1,   0, 0, 0, 1);
        add(1, 32'h14,    0, 0, 0, 0,   1, 5, 0, 1);
        add(0, 32'h0,     1, 5, 1, 1,   1, 5, 0, 1);
        add(0, 32'h0,     1, 5, 1, 1,   1, 5, 0, 1);
        add(0, 32'h0,     1, 5, 1, 1,   1, 5, 0, 1);
        add(0, 32'h0,     1, 5, 0, 0,   1, 5, 0, 0);
        add(1, 32'h14,    0, 0, 0, 0,   1, 5, 0, 0);
        add(0, 32'h0,     1, 3, 1, 0,   1, 5, 1, 1);
        add(0, 32'h0,     0, 0, 0, 0,   1, 5, 0, 1);
        add(0, 32'h0,     1, 3, 0, 0,   1, 5, 0, 0);
        add(1, 32'h1c,    1, 7, 1, 1,   0, 7, 0, 1);
        add(1, 32'h1c,    0, 0, 0, 0,   1, 7, 0, 1);
        add(0, 32'h0,     1, 2, 0, 1,   1, 7, 1, 0);
        add(0, 32'h0,     1, 2, 1, 0,   1, 7, 1, 1);
        add(0, 32'h0,     0, 0, 0, 0,   1, 7, 0, 1);
        for (int i = 0; i < tbl.size(); i++) begin
            step(0, tbl[i].fv, tbl[i].pc, tbl[i].rv, tbl[i].ri, tbl[i].rt, tbl[i].rp);
            chk($sformatf("vec%0d_pred_taken", i), int'(pred_taken), tbl[i].et);
            chk($sformatf("vec%0d_pred_index", i), int'(pred_index), tbl[i].ei);
            chk($sformatf("vec%0d_mispredict", i), int'(mispredict), tbl[i].em);
            chk($sformatf("vec%0d_redirect", i), int'(redirect_taken), tbl[i].er);
        end
`else
        // GHR after taken, taken, not-taken is 0110; PC 0x04 base index 1
        step(0, 0, 32'h0, 1, 0, 1, 1);
        step(0, 0, 32'h0, 1, 0, 1, 1);
        step(0, 0, 32'h0, 1, 0, 0, 0);
        step(0, 1, 32'h4, 0, 0, 0, 0);
        chk("gshare_pred_index", int'(pred_index), 7);
`endif

        // Randomized traffic with occasional reset
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 63) == 0), $urandom_range(0, 1), $urandom(),
                 $urandom_range(0, 1), $urandom_range(0, N - 1),
                 $urandom_range(0, 1), $urandom_range(0, 1));
        end

        // Train everything upward so the reset has something to clear
        for (int i = 0; i < N; i++) step(0, 0, 32'h0, 1, i, 1, 1);
        step(1, 1, 32'h8, 1, 3, 1, 0);
        chk("midreset_mispredict", int'(mispredict), 0);
        step(0, 0, 32'h0, 0, 0, 0, 0);
        chk("midreset_no_late_pulse", int'(mispredict), 0);
        // Only a counter at 01 predicts 0 now and 1 after a single taken
        for (int i = 0; i < N; i++) begin
            step(0, 1, 32'(i << 2), 0, 0, 0, 0);
            chk($sformatf("cleared_ctr%0d_nt", i), int'(pred_taken), 0);
        end
        for (int i = 0; i < N; i++) step(0, 0, 32'h0, 1, i, 1, 1);
        for (int i = 0; i < N; i++) begin
            step(0, 1, 32'(i << 2), 0, 0, 0, 0);
            chk($sformatf("cleared_ctr%0d_t", i), int'(pred_taken), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
